// File: rtl/regfile_dump_if.sv
// Word stream interface for the register-file dump reader.
// The master drives a valid/data/index/last word; the slave answers with ready.
interface regfile_dump_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/regfile_dump.sv
// regfile_dump: snapshots all architectural registers through a dedicated read
// port and streams them out one word at a time, holding the pipeline frozen for
// the whole dump.
// Optional feature macro: REGDUMP_CHECKSUM_EN appends an XOR checksum word
// (out_index 0, out_last set) after the last register.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | quiescent, waiting for start
// SETTLE | one cycle so an in-flight negedge register write lands
// STREAM | load one register per accepted slot, idx walks 0..last
// CSUM   | load the XOR checksum word (checksum build only)
// DRAIN  | wait for the final word to be accepted
// DONE   | one-cycle done pulse, then back to IDLE
module regfile_dump #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              freeze,
  output logic [ADDR_W-1:0] readAddress,
  input  logic [DATA_W-1:0] readData,
  output logic              busy,
  output logic              done,
  regfile_dump_if.master    dump_if
);

  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
`ifdef REGDUMP_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic              last_q, last_d;
  logic              ld;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc_q, acc_d;
`endif

  // Output slot can take a new word when it is empty or being drained this cycle.
  assign ld = !valid_q || dump_if.out_ready;

  // Next-state and datapath decode; everything holds unless a state acts on it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    index_d = index_q;
    last_d  = last_q;
`ifdef REGDUMP_CHECKSUM_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETTLE;
          idx_d   = '0;
`ifdef REGDUMP_CHECKSUM_EN
          acc_d   = '0;
`endif
        end
      end
      S_SETTLE: begin
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (ld) begin
          data_d  = readData;
          index_d = idx_q;
          valid_d = 1'b1;
          // idx wraps back to 0 after the last load, which also leaves
          // readAddress at 0 for the return to IDLE.
          idx_d   = idx_q + IDX_ONE;
`ifdef REGDUMP_CHECKSUM_EN
          acc_d   = acc_q ^ readData;
          last_d  = 1'b0;
          if (idx_q == LAST_IDX) state_d = S_CSUM;
`else
          last_d  = (idx_q == LAST_IDX);
          if (idx_q == LAST_IDX) state_d = S_DRAIN;
`endif
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      S_CSUM: begin
        if (ld) begin
          data_d  = acc_q;
          index_d = '0;
          last_d  = 1'b1;
          valid_d = 1'b1;
          state_d = S_DRAIN;
        end
      end
`endif
      S_DRAIN: begin
        if (valid_q && dump_if.out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous reset abandons any dump in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      index_q <= index_d;
      last_q  <= last_d;
`ifdef REGDUMP_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign readAddress       = idx_q;
  assign busy              = (state_q != S_IDLE);
  assign freeze            = busy;
  assign done              = (state_q == S_DONE);
  assign dump_if.out_valid = valid_q;
  assign dump_if.out_data  = data_q;
  assign dump_if.out_index = index_q;
  assign dump_if.out_last  = last_q;

endmodule
